// File: rtl/clk_sync.sv
// clk_sync: multi-flop level synchronizer for a single asynchronous input.
// Output is the input delayed by STAGES clock edges; all stages reset to 0.
module clk_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q, sync_d;

  // Shift the raw level in at bit 0 and towards the output bit.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  // Synchronizer chain with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// input_debounce: one channel of the scanner. Synchronizes the raw pin, then
// accepts a new level only after it has differed from the stable level for
// DEBOUNCE consecutive cycles. o_event is a combinational one-cycle pulse in
// the cycle the stable level flips; the new level is ~o_stable in that cycle.
module input_debounce #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_event
);

  logic             sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  clk_sync #(
    .STAGES (STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_raw),
    .o_q     (sync)
  );

  // Count disagreeing cycles; flip the stable level on the DEBOUNCE-th one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    o_event  = 1'b0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
      stable_d = sync;
      cnt_d    = '0;
      o_event  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce counter and stable level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign o_stable = stable_q;

endmodule

// File: rtl/ext_event_scan.sv
// ext_event_scan: turns level changes on N external pins into a single
// valid/ready event stream. Each channel is debounced, queued in a one-deep
// pending slot (newest level wins, loss flagged in o_overrun), and a
// round-robin arbiter loads the registered output port.
module ext_event_scan #(
  parameter  int unsigned N        = 4,
  parameter  int unsigned STAGES   = 3,
  parameter  int unsigned DEBOUNCE = 16,
  localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_ext,
  output logic [N-1:0]  o_stable,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_chan,
  output logic          o_level,
  output logic [N-1:0]  o_overrun,
  input  logic [N-1:0]  i_ovr_clr
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  logic [N-1:0]  stable;
  logic [N-1:0]  evt;

  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  plev_q, plev_d;
  logic [N-1:0]  ovr_q, ovr_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] chan_q, chan_d;
  logic          level_q, level_d;
  logic [CW-1:0] rr_q, rr_d;

  logic          slot_free;
  logic          grant;
  logic [CW-1:0] grant_idx;
  logic [CW-1:0] cand;
  int unsigned   idx;

  for (genvar g = 0; g < N; g++) begin : g_chan
    input_debounce #(
      .STAGES   (STAGES),
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_deb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_raw    (i_ext[g]),
      .o_stable (stable[g]),
      .o_event  (evt[g])
    );
  end

  // Round-robin pick: first pending channel at or after rr, when the slot frees.
  always_comb begin
    slot_free = !valid_q || i_ready;
    grant     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx  = (32'(rr_q) + k) % N;
      cand = CW'(idx);
      if (slot_free && !grant && pend_q[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Pending slots, overrun flags and the output register next state.
  always_comb begin
    pend_d  = pend_q;
    plev_d  = plev_q;
    ovr_d   = ovr_q & ~i_ovr_clr;
    valid_d = valid_q;
    chan_d  = chan_q;
    level_d = level_q;
    rr_d    = rr_q;

    for (int unsigned ch = 0; ch < N; ch++) begin
      if (grant && grant_idx == CW'(ch)) begin
        pend_d[ch] = 1'b0;
      end
      if (evt[ch]) begin
        // An ungranted full slot gets overwritten: the older level is lost.
        if (pend_q[ch] && !(grant && grant_idx == CW'(ch))) begin
          ovr_d[ch] = 1'b1;
        end
        pend_d[ch] = 1'b1;
        // The event flips the stable level, so the new level is its complement.
        plev_d[ch] = ~stable[ch];
      end
    end

    if (slot_free) begin
      valid_d = grant;
      if (grant) begin
        chan_d  = grant_idx;
        level_d = plev_q[grant_idx];
        rr_d    = (grant_idx == CW'(N - 1)) ? '0 : grant_idx + CW'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q  <= '0;
      plev_q  <= '0;
      ovr_q   <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      level_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      plev_q  <= plev_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      level_q <= level_d;
      rr_q    <= rr_d;
    end
  end

  assign o_stable  = stable;
  assign o_valid   = valid_q;
  assign o_chan    = chan_q;
  assign o_level   = level_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_ext_event_scan.sv
// Directed bench for ext_event_scan with N=4, STAGES=3, DEBOUNCE=4.
module tb_ext_event_scan;

  localparam int unsigned N        = 4;
  localparam int unsigned STAGES   = 3;
  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned CW       = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  ext = '0;
  logic [N-1:0]  ovr_clr = '0;
  logic          ready = 1'b1;
  logic [N-1:0]  stable;
  logic [N-1:0]  overrun;
  logic          valid;
  logic          level;
  logic [CW-1:0] chan;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ext_event_scan #(
    .N        (N),
    .STAGES   (STAGES),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ext     (ext),
    .o_stable  (stable),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_chan    (chan),
    .o_level   (level),
    .o_overrun (overrun),
    .i_ovr_clr (ovr_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input int c, input logic l);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_chan"}, 32'(chan), 32'(c));
    chk({tag, "_level"}, 32'(level), 32'(l));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i;
    i = 0;
    while (valid !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    chk({tag, "_wait"}, 32'(valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset and idle
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_stable", 32'(stable), 32'd0);
      chk("idle_ovr", 32'(overrun), 32'd0);
    end

    // 2. Latency: ch2 rises, sampled at edge 0, valid after edge 7
    ext[2] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("lat_early_valid", 32'(valid), 32'd0);
    end
    step();
    chk_evt("lat_evt", 2, 1'b1);
    chk("lat_stable", 32'(stable), 32'h4);
    step();
    chk("lat_drop", 32'(valid), 32'd0);

    // 3. Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
    ext[1] = 1'b1;
    repeat (3) step();
    ext[1] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("glitch_valid", 32'(valid), 32'd0);
    end
    chk("glitch_stable", 32'(stable), 32'h4);
    ext[1] = 1'b1;
    repeat (4) step();
    ext[1] = 1'b0;
    wait_valid("pulse_rise", 10);
    chk_evt("pulse_rise", 1, 1'b1);
    chk("pulse_rise_stable", 32'(stable), 32'h6);
    step();
    chk("pulse_rise_drop", 32'(valid), 32'd0);
    wait_valid("pulse_fall", 12);
    chk_evt("pulse_fall", 1, 1'b0);
    chk("pulse_fall_stable", 32'(stable), 32'h4);
    step();

    // Return to a known rr=0 with all inputs low
    ext = '0;
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst2_valid", 32'(valid), 32'd0);
    end

    // 4. Round robin: rr=0 gives 0 then 3
    ext = 4'b1001;
    wait_valid("rr0", 12);
    chk_evt("rr0_first", 0, 1'b1);
    step();
    chk_evt("rr0_second", 3, 1'b1);
    step();
    chk("rr0_drop", 32'(valid), 32'd0);
    // Lone ch0 grant leaves rr=1
    ext[0] = 1'b0;
    wait_valid("rr_set", 12);
    chk_evt("rr_set", 0, 1'b0);
    step();
    // ch0 rises and ch3 falls together: ch3 wins from rr=1
    ext = 4'b0001;
    wait_valid("rr1", 12);
    chk_evt("rr1_first", 3, 1'b0);
    step();
    chk_evt("rr1_second", 0, 1'b1);
    step();
    chk("rr1_drop", 32'(valid), 32'd0);

    // 5. Backpressure and overrun on ch0
    ext[0] = 1'b0;
    wait_valid("bp_pre", 12);
    chk_evt("bp_pre", 0, 1'b0);
    step();
    chk("bp_pre_drop", 32'(valid), 32'd0);
    ready = 1'b0;
    ext[0] = 1'b1;
    repeat (8) step();
    chk_evt("bp_held1", 0, 1'b1);
    ext[0] = 1'b0;
    repeat (8) step();
    chk_evt("bp_held2", 0, 1'b1);
    chk("bp_no_ovr", 32'(overrun), 32'd0);
    ext[0] = 1'b1;
    repeat (8) step();
    chk_evt("bp_held3", 0, 1'b1);
    chk("bp_ovr", 32'(overrun), 32'h1);
    ready = 1'b1;
    step();
    chk_evt("bp_second", 0, 1'b1);
    step();
    chk("bp_drop", 32'(valid), 32'd0);
    chk("bp_ovr_sticky", 32'(overrun), 32'h1);
    ovr_clr = 4'b0001;
    step();
    ovr_clr = '0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // 6. Async reset mid-cycle while valid, with overruns present
    ready = 1'b0;
    ext = 4'b1111;
    wait_valid("pre_rst", 12);
    chk_evt("pre_rst", 1, 1'b1);
    ext = 4'b0011;
    repeat (10) step();
    chk("pre_rst_ovr", 32'(overrun), 32'hc);
    chk_evt("pre_rst_hold", 1, 1'b1);
    ext = 4'b1111;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_stable", 32'(stable), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    ready = 1'b1;
    step();
    #3;
    rst_n = 1'b1;
    wait_valid("post_rst", 15);
    chk_evt("post_rst0", 0, 1'b1);
    step();
    chk_evt("post_rst1", 1, 1'b1);
    step();
    chk_evt("post_rst2", 2, 1'b1);
    step();
    chk_evt("post_rst3", 3, 1'b1);
    chk("post_rst_stable", 32'(stable), 32'hf);
    step();
    chk("post_rst_drop", 32'(valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
